// File: rtl/corescore_bridge_pkg.sv
// Shared types, constants and the round-robin search for the stream-to-UART bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package corescore_bridge_pkg;

    // Arbiter states: scan for a channel, optionally emit a tag byte, forward the message.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // ASCII '0'; the header byte is HDR_BASE + channel index.
    localparam logic [7:0] HDR_BASE = 8'h30;

    // Upper bound on channels. A single ASCII digit can only tag ten channels.
    localparam int MAX_CH = 10;
    localparam int CH_W   = 4;

    // Round-robin search: the first set bit of vld at or after start, wrapping at nch.
    // The result is {hit, index}. When nothing is valid, hit is 0 and index is 0.
    function automatic logic [CH_W:0] rr_search(
        input logic [MAX_CH-1:0] vld,
        input logic [CH_W-1:0]   start,
        input int                nch
    );
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < nch && !res[CH_W]) begin
                idx = (int'(start) + i) % nch;
                if (vld[idx[CH_W-1:0]]) begin
                    res = {1'b1, idx[CH_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/corescore_bridge_fifo.sv
// Byte FIFO between the arbiter and the sink register. It has a combinational head read.
// Latency: a push is visible at dout and in level the cycle after the write edge.
// Backpressure: a push while full or a pop while empty is ignored; full and empty come from the registered level.
// Ports: clk/rst_n (async active-low), push/din write side, pop/dout read side,
//        full/empty flags, level = occupancy 0..DEPTH.
module corescore_bridge_fifo
    import corescore_bridge_pkg::*;
#(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // The storage has no reset. Clearing the pointers is enough to discard its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap without a compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/corescore_stream_uart_bridge.sv
// Bridge from NCH AXI byte streams to a UART-style byte sink. Arbitration is message-atomic round robin, with an optional ASCII channel tag.
// Latency: the earliest sink strobe is 2 cycles after a byte is accepted; arbitration costs 1 idle cycle (+1 with header).
// Backpressure: o_tready drops when the FIFO is full; the sink throttles through i_sink_ena, one byte per enabled cycle.
// Ports: i_clk/i_rst_n (async active-low); i_tdata/i_tlast/i_tvalid/o_tready per-channel streams,
//        channel c on i_tdata[8c+7:8c]; i_sink_ena/o_sink_dat/o_sink_val sink side; o_level FIFO occupancy.
module corescore_stream_uart_bridge
    import corescore_bridge_pkg::*;
#(
    parameter  int NCH    = 4,
    parameter  int DEPTH  = 64,
    parameter  int HDR_EN = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NCH*8-1:0] i_tdata,
    input  logic [NCH-1:0]   i_tlast,
    input  logic [NCH-1:0]   i_tvalid,
    output logic [NCH-1:0]   o_tready,
    input  logic             i_sink_ena,
    output logic [7:0]       o_sink_dat,
    output logic             o_sink_val,
    output logic [AW:0]      o_level
);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [MAX_CH-1:0] vld_ext;
    logic [CH_W:0]     pick;

    logic              sel_vld;
    logic              sel_last;
    logic [7:0]        sel_dat;

    logic              push;
    logic [7:0]        push_dat;
    logic              pop;
    logic [7:0]        fifo_dout;
    logic              full;
    logic              empty;

    corescore_bridge_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (push),
        .din   (push_dat),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (o_level)
    );

    // The granted channel's stream, selected by compare so the index width is independent of NCH.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_dat  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_vld  = i_tvalid[c];
                sel_last = i_tlast[c];
                sel_dat  = i_tdata[8*c +: 8];
            end
        end
    end

    // Ready comes from the registered state and level only. It never loops back from i_tvalid.
    always_comb begin
        o_tready = '0;
        for (int c = 0; c < NCH; c++) begin
            o_tready[c] = (state_q == DATA) && !full && (grant_q == CH_W'(c));
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        push     = 1'b0;
        push_dat = sel_dat;
        vld_ext  = '0;
        vld_ext[NCH-1:0] = i_tvalid;
        pick     = rr_search(vld_ext, rr_q, NCH);

        case (state_q)
            IDLE: begin
                if (pick[CH_W]) begin
                    grant_d = pick[CH_W-1:0];
                    state_d = (HDR_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                if (!full) begin
                    push     = 1'b1;
                    push_dat = HDR_BASE + 8'(grant_q);
                    state_d  = DATA;
                end
            end
            DATA: begin
                // The grant is held until tlast, even if the channel drops valid mid-message.
                if (sel_vld && !full) begin
                    push = 1'b1;
                    if (sel_last) begin
                        rr_d    = (grant_q == CH_W'(NCH-1)) ? '0 : grant_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // The UART takes a byte the cycle after it raised its enable, so the strobe lags the pop by one cycle.
    assign pop = i_sink_ena && !empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sink_val <= 1'b0;
            o_sink_dat <= '0;
        end else begin
            o_sink_val <= pop;
            if (pop) begin
                o_sink_dat <= fifo_dout;
            end
        end
    end

endmodule

// File: tb/tb_corescore_stream_uart_bridge.sv
// Directed bench with two bridge instances: A (4 ch, depth 4, no header) and B (4 ch, depth 8, header).
// Latency: n/a. Sink bytes are compared in order against scoreboard queues that the stimulus fills.
// Backpressure: the sink enable of each instance is driven by the directed sequence.
module tb_corescore_stream_uart_bridge;

    typedef struct packed {
        logic [1:0] ch;
        logic       last;
        logic [7:0] dat;
    } beat_t;

    logic        clk;
    logic        rst_n_a, rst_n_b;

    logic [31:0] a_tdata, b_tdata;
    logic [3:0]  a_tlast, b_tlast;
    logic [3:0]  a_tvalid, b_tvalid;
    logic [3:0]  a_tready, b_tready;
    logic        a_ena, b_ena;
    logic [7:0]  a_dat, b_dat;
    logic        a_val, b_val;
    logic [2:0]  a_level;
    logic [3:0]  b_level;

    beat_t       src_a[$];
    beat_t       src_b[$];
    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          first_acc_a = -1;
    int          first_val_a = -1;

    corescore_stream_uart_bridge #(.NCH(4), .DEPTH(4), .HDR_EN(0)) dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n_a),
        .i_tdata    (a_tdata),
        .i_tlast    (a_tlast),
        .i_tvalid   (a_tvalid),
        .o_tready   (a_tready),
        .i_sink_ena (a_ena),
        .o_sink_dat (a_dat),
        .o_sink_val (a_val),
        .o_level    (a_level)
    );

    corescore_stream_uart_bridge #(.NCH(4), .DEPTH(8), .HDR_EN(1)) dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n_b),
        .i_tdata    (b_tdata),
        .i_tlast    (b_tlast),
        .i_tvalid   (b_tvalid),
        .o_tready   (b_tready),
        .i_sink_ena (b_ena),
        .o_sink_dat (b_dat),
        .o_sink_val (b_val),
        .o_level    (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic beat_t mk(input int ch, input bit last, input int d);
        beat_t b;
        b.ch   = 2'(ch);
        b.last = last;
        b.dat  = 8'(d);
        return b;
    endfunction

    // Source model: each channel presents the oldest queued beat for that channel. The beat retires after a handshake.
    always @(posedge clk) begin
        logic [3:0] hs_a, hs_b;
        logic       found;
        hs_a = a_tvalid & a_tready;
        hs_b = b_tvalid & b_tready;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hs_a[c]) begin
                found = 1'b0;
                for (int i = 0; i < src_a.size(); i++)
                    if (!found && src_a[i].ch == 2'(c)) begin src_a.delete(i); found = 1'b1; end
            end
            if (hs_b[c]) begin
                found = 1'b0;
                for (int i = 0; i < src_b.size(); i++)
                    if (!found && src_b[i].ch == 2'(c)) begin src_b.delete(i); found = 1'b1; end
            end
        end
        a_tvalid = '0; a_tlast = '0;
        b_tvalid = '0; b_tlast = '0;
        for (int c = 0; c < 4; c++) begin
            found = 1'b0;
            for (int i = 0; i < src_a.size(); i++)
                if (!found && src_a[i].ch == 2'(c)) begin
                    found = 1'b1; a_tvalid[c] = 1'b1; a_tlast[c] = src_a[i].last; a_tdata[8*c +: 8] = src_a[i].dat;
                end
            found = 1'b0;
            for (int i = 0; i < src_b.size(); i++)
                if (!found && src_b[i].ch == 2'(c)) begin
                    found = 1'b1; b_tvalid[c] = 1'b1; b_tlast[c] = src_b[i].last; b_tdata[8*c +: 8] = src_b[i].dat;
                end
        end
    end

    // Sink monitor: every strobe must match the next expected byte.
    always @(negedge clk) begin
        cyc++;
        if (rst_n_a) begin
            chk("onehot_ready_a", 32'($onehot0(a_tready)), 32'd1);
            if (first_acc_a < 0 && (a_tvalid & a_tready) != 4'b0) first_acc_a = cyc;
            if (a_val) begin
                if (first_val_a < 0) first_val_a = cyc;
                chk("sink_expected_a", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) chk("sink_dat_a", 32'(a_dat), 32'(exp_a.pop_front()));
            end
        end
        if (rst_n_b) begin
            chk("onehot_ready_b", 32'($onehot0(b_tready)), 32'd1);
            if (b_val) begin
                chk("sink_expected_b", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) chk("sink_dat_b", 32'(b_dat), 32'(exp_b.pop_front()));
            end
        end
    end

    task automatic drain_a(input string tag);
        int i;
        i = 0;
        while ((exp_a.size() != 0 || src_a.size() != 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drained_a"}, 32'(exp_a.size()), 32'd0);
        chk({tag, "_level_a"}, 32'(a_level), 32'd0);
    endtask

    task automatic drain_b(input string tag);
        int i;
        i = 0;
        while ((exp_b.size() != 0 || src_b.size() != 0) && i < 300) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drained_b"}, 32'(exp_b.size()), 32'd0);
        chk({tag, "_level_b"}, 32'(b_level), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int i;
        a_ena = 1'b0; b_ena = 1'b0;
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_tready_a", 32'(a_tready), 32'd0);
        chk("rst_val_a",    32'(a_val),    32'd0);
        chk("rst_dat_a",    32'(a_dat),    32'd0);
        chk("rst_level_a",  32'(a_level),  32'd0);
        chk("rst_tready_b", 32'(b_tready), 32'd0);
        chk("rst_level_b",  32'(b_level),  32'd0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(negedge clk);
        chk("idle_tready_a", 32'(a_tready), 32'd0);

        // B: round robin with headers; grants 0,1,2,3,0 and messages never interleave
        b_ena = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_b.push_back(8'(8'h30 + c));
            exp_b.push_back(8'(8'hA0 + 2*c));
            exp_b.push_back(8'(8'hA1 + 2*c));
            src_b.push_back(mk(c, 1'b0, 8'hA0 + 2*c));
            src_b.push_back(mk(c, 1'b1, 8'hA1 + 2*c));
        end
        exp_b.push_back(8'h30); exp_b.push_back(8'hB0); exp_b.push_back(8'hB1);
        src_b.push_back(mk(0, 1'b0, 8'hB0));
        src_b.push_back(mk(0, 1'b1, 8'hB1));
        drain_b("rr");

        // B: header for channel 3
        exp_b.push_back(8'h33); exp_b.push_back(8'h41);
        src_b.push_back(mk(3, 1'b1, 8'h41));
        drain_b("hdr");

        // A: "Hi\n" on channel 0 with the sink always enabled
        a_ena = 1'b1;
        exp_a.push_back(8'h48); exp_a.push_back(8'h69); exp_a.push_back(8'h0A);
        src_a.push_back(mk(0, 1'b0, 8'h48));
        src_a.push_back(mk(0, 1'b0, 8'h69));
        src_a.push_back(mk(0, 1'b1, 8'h0A));
        drain_a("hi");
        chk("hi_first_strobe_latency", 32'(first_val_a - first_acc_a), 32'd2);

        // A: backpressure with the sink disabled until the FIFO is full
        a_ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_a.push_back(8'(8'hC0 + k));
            src_a.push_back(mk(2, k == 4, 8'hC0 + k));
        end
        repeat (12) @(negedge clk);
        chk("bp_level_full", 32'(a_level),  32'd4);
        chk("bp_tready_low", 32'(a_tready), 32'd0);
        a_ena = 1'b1;
        @(negedge clk);
        chk("bp_level_after_pop", 32'(a_level),  32'd3);
        chk("bp_tready_rise",     32'(a_tready), 32'b0100);
        drain_a("bp");

        // A: simultaneous push and pop at level 2, across pointer wrap-around
        a_ena = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_a.push_back(8'(8'h50 + k));
            src_a.push_back(mk(1, k == 9, 8'h50 + k));
        end
        i = 0;
        while (a_level != 3'd2 && i < 50) begin @(negedge clk); i++; end
        chk("wrap_reach_level2", 32'(a_level), 32'd2);
        a_ena = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("wrap_level_hold", 32'(a_level), 32'd2);
        end
        drain_a("wrap");

        // A: asynchronous reset mid-message at level 3, then rr must restart at 0
        a_ena = 1'b0;
        src_a.push_back(mk(1, 1'b1, 8'h11));
        for (int k = 0; k < 4; k++) src_a.push_back(mk(2, k == 3, 8'h22 + k));
        i = 0;
        while (a_level != 3'd3 && i < 50) begin @(negedge clk); i++; end
        chk("rst_mid_level", 32'(a_level), 32'd3);
        rst_n_a = 1'b0;
        #1;
        chk("rst_mid_tready", 32'(a_tready), 32'd0);
        chk("rst_mid_val",    32'(a_val),    32'd0);
        chk("rst_mid_dat",    32'(a_dat),    32'd0);
        chk("rst_mid_level0", 32'(a_level),  32'd0);
        src_a.delete();
        exp_a.delete();
        src_a.push_back(mk(3, 1'b1, 8'h73));
        src_a.push_back(mk(1, 1'b1, 8'h71));
        exp_a.push_back(8'h71);
        exp_a.push_back(8'h73);
        repeat (3) @(negedge clk);
        a_ena = 1'b1;
        rst_n_a = 1'b1;
        drain_a("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
